// File: rtl/ahb_gpio_par_pkg.sv
// ahb_gpio_pkg: shared definitions for the parametrised AHB-Lite parity GPIO.
//   - byte offsets of the six implemented registers
//   - bit positions inside PCTRL
//   - aphase_t: the address-phase information carried into the data phase
package ahb_gpio_pkg;

    localparam logic [7:0] DATA_OFF    = 8'h00;
    localparam logic [7:0] DIR_OFF     = 8'h04;
    localparam logic [7:0] IRQEN_OFF   = 8'h08;
    localparam logic [7:0] IRQSTAT_OFF = 8'h0C;
    localparam logic [7:0] PCTRL_OFF   = 8'h10;
    localparam logic [7:0] PCNT_OFF    = 8'h14;

    localparam int PCTRL_PSEL_BIT  = 0;   // 0 = even, 1 = odd parity
    localparam int PCTRL_CHKEN_BIT = 1;   // enable input parity checking
    localparam int PCTRL_PERR_BIT  = 8;   // sticky error, write-1-to-clear

    typedef struct packed {
        logic       valid;
        logic       write;
        logic [2:0] idx;      // HADDR[4:2]
    } aphase_t;

endpackage

// File: rtl/gpio_in_sync.sv
// gpio_in_sync: two-flop synchroniser for the pad inputs plus a delayed copy
// of the synchronised value used for rising-edge detection.
// Ports:
//   clk, srst   clock and synchronous active-high reset
//   din         raw pad inputs (WIDTH data bits + parity bit at WIDTH)
//   s2          synchronised inputs, all WIDTH+1 bits
//   rise        one-cycle rising-edge pulse per data bit
module gpio_in_sync
    import ahb_gpio_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             srst,
    input  logic [WIDTH:0]   din,
    output logic [WIDTH:0]   s2,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH:0]   s1_reg;
    logic [WIDTH:0]   s2_reg;
    // The parity bit never raises an interrupt, so only data bits are delayed.
    logic [WIDTH-1:0] s3_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            s1_reg <= '0;
            s2_reg <= '0;
            s3_reg <= '0;
        end else begin
            s1_reg <= din;
            s2_reg <= s1_reg;
            s3_reg <= s2_reg[WIDTH-1:0];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_rise
            assign rise[gi] = s2_reg[gi] & ~s3_reg[gi];
        end
    endgenerate

    assign s2 = s2_reg;

endmodule

// File: rtl/ahb_gpio_par.sv
// ahb_gpio_par: AHB-Lite GPIO slave with per-bit direction, programmable
// output parity, input parity checking with a saturating error counter and
// rising-edge interrupts. Zero wait states.
// Ports:
//   HCLK/HRESET      bus clock, synchronous active-high reset
//   HSEL..HREADY     AHB-Lite slave inputs (only HADDR[4:2] decoded)
//   HREADYOUT        tied high
//   HRDATA           read data, driven only in a read data phase
//   GPIOIN           pad inputs, bit WIDTH is the incoming parity bit
//   GPIOOUT          output latch plus generated parity at bit WIDTH
//   GPIODIR          per-bit output enable
//   IRQ              registered OR of enabled pending edges
//   PARITYERR        registered live input parity mismatch
module ahb_gpio_par
    import ahb_gpio_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             HCLK,
    input  logic             HRESET,
    input  logic             HSEL,
    input  logic [31:0]      HADDR,
    input  logic [1:0]       HTRANS,
    input  logic             HWRITE,
    input  logic [31:0]      HWDATA,
    input  logic             HREADY,
    output logic             HREADYOUT,
    output logic [31:0]      HRDATA,
    input  logic [WIDTH:0]   GPIOIN,
    output logic [WIDTH:0]   GPIOOUT,
    output logic [WIDTH-1:0] GPIODIR,
    output logic             IRQ,
    output logic             PARITYERR
);

    localparam logic [2:0] IDX_DATA    = DATA_OFF[4:2];
    localparam logic [2:0] IDX_DIR     = DIR_OFF[4:2];
    localparam logic [2:0] IDX_IRQEN   = IRQEN_OFF[4:2];
    localparam logic [2:0] IDX_IRQSTAT = IRQSTAT_OFF[4:2];
    localparam logic [2:0] IDX_PCTRL   = PCTRL_OFF[4:2];
    localparam logic [2:0] IDX_PCNT    = PCNT_OFF[4:2];
    localparam logic [CNT_W-1:0] PCNT_MAX = '1;

    aphase_t          aph_reg, aph_next;
    logic [5:0]       wsel;
    logic [WIDTH-1:0] latch_reg, dir_reg, irqen_reg, irqstat_reg, irqstat_next;
    logic             psel_reg, chken_reg, perr_reg, perr_next;
    logic [CNT_W-1:0] pcnt_reg, pcnt_next;
    logic             parerr_reg, parerr_dly_reg, irq_reg;
    logic             mismatch, perr_pulse;
    logic [WIDTH:0]   sync_s2;
    logic [WIDTH-1:0] sync_rise;
    logic [31:0]      rdata;
    logic             unused_bits;

    // ---------------- bus address/data phase ----------------
    always_comb begin
        aph_next = '0;
        if (HSEL && HREADY && HTRANS[1]) begin
            aph_next.valid = 1'b1;
            aph_next.write = HWRITE;
            aph_next.idx   = HADDR[4:2];
        end
    end

    // Reset clears the registered phase, so a data phase in flight is dropped.
    always_ff @(posedge HCLK) begin
        if (HRESET) aph_reg <= '0;
        else        aph_reg <= aph_next;
    end

    // One write strobe per implemented register; offsets 0x18/0x1C decode to nothing.
    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_wsel
            assign wsel[gi] = aph_reg.valid & aph_reg.write & (aph_reg.idx == 3'(gi));
        end
    endgenerate

    // ---------------- input path ----------------
    gpio_in_sync #(.WIDTH(WIDTH)) u_sync (
        .clk  (HCLK),
        .srst (HRESET),
        .din  (GPIOIN),
        .s2   (sync_s2),
        .rise (sync_rise)
    );

    assign mismatch   = chken_reg & ((^sync_s2) != psel_reg);
    // Count entries into the error state, not cycles spent in it.
    assign perr_pulse = parerr_reg & ~parerr_dly_reg;

    always_comb begin
        irqstat_next = irqstat_reg;
        if (wsel[IDX_IRQSTAT])
            irqstat_next = irqstat_reg & ~HWDATA[WIDTH-1:0];
        irqstat_next = irqstat_next | sync_rise;    // a new edge beats a same-cycle clear

        pcnt_next = pcnt_reg;
        if (perr_pulse) begin
            if (pcnt_reg != PCNT_MAX)
                pcnt_next = pcnt_reg + CNT_W'(1);
        end else if (wsel[IDX_PCNT]) begin
            pcnt_next = '0;
        end

        perr_next = perr_reg;
        if (perr_pulse)
            perr_next = 1'b1;
        else if (wsel[IDX_PCTRL] && HWDATA[PCTRL_PERR_BIT])
            perr_next = 1'b0;
    end

    // ---------------- register file ----------------
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            latch_reg      <= '0;
            dir_reg        <= '0;
            irqen_reg      <= '0;
            irqstat_reg    <= '0;
            psel_reg       <= 1'b0;
            chken_reg      <= 1'b0;
            perr_reg       <= 1'b0;
            pcnt_reg       <= '0;
            parerr_reg     <= 1'b0;
            parerr_dly_reg <= 1'b0;
            irq_reg        <= 1'b0;
        end else begin
            if (wsel[IDX_DATA])  latch_reg <= HWDATA[WIDTH-1:0];
            if (wsel[IDX_DIR])   dir_reg   <= HWDATA[WIDTH-1:0];
            if (wsel[IDX_IRQEN]) irqen_reg <= HWDATA[WIDTH-1:0];
            if (wsel[IDX_PCTRL]) begin
                psel_reg  <= HWDATA[PCTRL_PSEL_BIT];
                chken_reg <= HWDATA[PCTRL_CHKEN_BIT];
            end
            irqstat_reg    <= irqstat_next;
            perr_reg       <= perr_next;
            pcnt_reg       <= pcnt_next;
            parerr_reg     <= mismatch;
            parerr_dly_reg <= parerr_reg;
            irq_reg        <= |(irqstat_reg & irqen_reg);
        end
    end

    // ---------------- read mux ----------------
    always_comb begin
        rdata = '0;
        if (aph_reg.valid && !aph_reg.write) begin
            case (aph_reg.idx)
                IDX_DATA:    rdata[WIDTH-1:0] = (latch_reg & dir_reg) | (sync_s2[WIDTH-1:0] & ~dir_reg);
                IDX_DIR:     rdata[WIDTH-1:0] = dir_reg;
                IDX_IRQEN:   rdata[WIDTH-1:0] = irqen_reg;
                IDX_IRQSTAT: rdata[WIDTH-1:0] = irqstat_reg;
                IDX_PCTRL: begin
                    rdata[PCTRL_PSEL_BIT]  = psel_reg;
                    rdata[PCTRL_CHKEN_BIT] = chken_reg;
                    rdata[PCTRL_PERR_BIT]  = perr_reg;
                end
                IDX_PCNT:    rdata[CNT_W-1:0] = pcnt_reg;
                default:     rdata = '0;
            endcase
        end
    end

    assign HRDATA    = rdata;
    assign HREADYOUT = 1'b1;
    assign GPIOOUT   = {psel_reg ? ~(^latch_reg) : (^latch_reg), latch_reg};
    assign GPIODIR   = dir_reg;
    assign IRQ       = irq_reg;
    assign PARITYERR = parerr_reg;

    // Address bits outside [4:2], HTRANS[0] and upper write data are don't-care.
    assign unused_bits = ^{HADDR[31:5], HADDR[1:0], HTRANS[0], HWDATA};

endmodule

// File: tb/tb_ahb_gpio_par.sv
// tb_ahb_gpio_par: directed scenarios plus a randomized phase, all checked
// against a cycle-level behavioural model of the GPIO kept in this file.
module tb_ahb_gpio_par;

    localparam int W  = 16;
    localparam int CW = 8;

    logic          HCLK = 1'b0;
    logic          HRESET, HSEL, HWRITE, HREADY;
    logic [31:0]   HADDR, HWDATA, HRDATA;
    logic [1:0]    HTRANS;
    logic          HREADYOUT, IRQ, PARITYERR;
    logic [W:0]    GPIOIN, GPIOOUT;
    logic [W-1:0]  GPIODIR;

    int checks = 0;
    int errors = 0;

    ahb_gpio_par #(.WIDTH(W), .CNT_W(CW)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY), .HREADYOUT(HREADYOUT),
        .HRDATA(HRDATA), .GPIOIN(GPIOIN), .GPIOOUT(GPIOOUT), .GPIODIR(GPIODIR),
        .IRQ(IRQ), .PARITYERR(PARITYERR)
    );

    always #5 HCLK = ~HCLK;

    // ---------------- reference model ----------------
    logic [W-1:0]  m_latch, m_dir, m_irqen, m_irqstat;
    logic          m_psel, m_chken, m_perr, m_parerr, m_parerr_d, m_irq;
    logic [CW-1:0] m_pcnt;
    logic [W:0]    hist [4];     // pad samples taken at the last four edges, [0] newest
    logic          p_valid, p_write;
    logic [2:0]    p_idx;

    task automatic model_reset();
        m_latch = '0; m_dir = '0; m_irqen = '0; m_irqstat = '0;
        m_psel = 0; m_chken = 0; m_perr = 0; m_parerr = 0; m_parerr_d = 0; m_irq = 0;
        m_pcnt = '0;
        for (int k = 0; k < 4; k++) hist[k] = '0;
        p_valid = 0; p_write = 0; p_idx = '0;
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_edge();
        logic [W-1:0] rise, w1c;
        logic         new_parerr, new_irq, pulse, clr_cnt, clr_perr;
        if (HRESET) begin
            model_reset();
            return;
        end
        pulse = m_parerr && !m_parerr_d;
        hist[3] = hist[2]; hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = GPIOIN;
        // Logic sees pad values two samples late; an edge is that view vs the one before.
        rise       = hist[2][W-1:0] & ~hist[3][W-1:0];
        new_parerr = m_chken && ((^hist[2]) != m_psel);
        new_irq    = |(m_irqstat & m_irqen);
        w1c = '0; clr_cnt = 0; clr_perr = 0;
        if (p_valid && p_write) begin
            case (p_idx)
                3'd0: m_latch = HWDATA[W-1:0];
                3'd1: m_dir   = HWDATA[W-1:0];
                3'd2: m_irqen = HWDATA[W-1:0];
                3'd3: w1c     = HWDATA[W-1:0];
                3'd4: begin m_psel = HWDATA[0]; m_chken = HWDATA[1]; clr_perr = HWDATA[8]; end
                3'd5: clr_cnt = 1;
                default: ;
            endcase
        end
        m_irqstat = (m_irqstat & ~w1c) | rise;
        if (pulse) begin
            if (m_pcnt < CW'(255)) m_pcnt = m_pcnt + 1'b1;
            m_perr = 1;
        end else begin
            if (clr_cnt)  m_pcnt = '0;
            if (clr_perr) m_perr = 0;
        end
        m_parerr_d = m_parerr;
        m_parerr   = new_parerr;
        m_irq      = new_irq;
        p_valid = HSEL && HREADY && HTRANS[1];
        p_write = HWRITE;
        p_idx   = HADDR[4:2];
    endtask

    function automatic logic [31:0] model_read(input logic [2:0] idx);
        logic [31:0] r;
        r = '0;
        case (idx)
            3'd0: r[W-1:0] = (m_latch & m_dir) | (hist[1][W-1:0] & ~m_dir);
            3'd1: r[W-1:0] = m_dir;
            3'd2: r[W-1:0] = m_irqen;
            3'd3: r[W-1:0] = m_irqstat;
            3'd4: begin r[0] = m_psel; r[1] = m_chken; r[8] = m_perr; end
            3'd5: r[CW-1:0] = m_pcnt;
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] model_hrdata();
        return (p_valid && !p_write) ? model_read(p_idx) : 32'h0;
    endfunction

    function automatic logic [W:0] model_gpioout();
        logic par;
        par = ^m_latch;
        if (m_psel) par = ~par;
        return {par, m_latch};
    endfunction

    // ---------------- checking / driving helpers ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        model_edge();
        #1;
    endtask

    task automatic check_pins(input string tag);
        check({tag, "_gpioout"}, 32'(GPIOOUT), 32'(model_gpioout()));
        check({tag, "_gpiodir"}, 32'(GPIODIR), 32'(m_dir));
        check({tag, "_irq"}, 32'(IRQ), 32'(m_irq));
        check({tag, "_parerr"}, 32'(PARITYERR), 32'(m_parerr));
        check({tag, "_hreadyout"}, 32'(HREADYOUT), 32'h1);
    endtask

    task automatic bus_idle();
        HSEL = 0; HTRANS = 2'b00; HWRITE = 0; HREADY = 1;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        HSEL = 1; HTRANS = 2'b10; HWRITE = 1; HADDR = addr;
        step();
        bus_idle(); HWDATA = data;
        step();
        $display("WR addr=%h data=%h", addr, data);
    endtask

    task automatic bus_read(input logic [31:0] addr, input string tag, output logic [31:0] rd);
        HSEL = 1; HTRANS = 2'b10; HWRITE = 0; HADDR = addr;
        step();
        bus_idle();
        rd = HRDATA;
        check(tag, rd, model_hrdata());
        $display("RD addr=%h data=%h", addr, rd);
        step();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] rd, rnd, addr;
        int r;

        model_reset();
        HRESET = 1; bus_idle(); HADDR = '0; HWDATA = '0; GPIOIN = '0;
        repeat (3) step();
        HRESET = 0;
        step();

        // Reset state.
        check_pins("rst");
        check("rst_gpioout_zero", 32'(GPIOOUT), 32'h0);
        check("rst_hrdata_idle", HRDATA, 32'h0);
        for (int k = 0; k < 6; k++) begin
            bus_read(32'(k * 4), "rst_reg", rd);
            check("rst_reg_zero", rd, 32'h0);
        end

        // Output parity.
        bus_write(32'h00, 32'h0007);
        bus_write(32'h04, 32'hFFFF);
        check("par_even", 32'(GPIOOUT), 32'h10007);
        check_pins("par_even");
        bus_write(32'h10, 32'h1);
        check("par_odd", 32'(GPIOOUT), 32'h00007);
        check_pins("par_odd");

        // Mixed direction read: input visible after two edges.
        bus_write(32'h04, 32'h00FF);
        GPIOIN = 17'h0AB00;
        step();
        bus_read(32'h00, "data_mixed", rd);
        check("data_mixed_const", rd, 32'h0000AB07);

        // Rising-edge interrupt.
        bus_write(32'h08, 32'h1);
        GPIOIN = 17'h0AB01;
        repeat (4) step();
        check("irq_raise", 32'(IRQ), 32'h1);
        check_pins("irq_raise");
        bus_read(32'h0C, "irqstat_set", rd);
        check("irqstat_b0", 32'(rd[0]), 32'h1);
        bus_write(32'h0C, 32'hFFFF);
        step();
        check("irq_cleared", 32'(IRQ), 32'h0);
        bus_read(32'h0C, "irqstat_clr", rd);
        check("irqstat_clr_const", rd, 32'h0);

        // Edge arrival coinciding with a write-1-to-clear: set wins.
        GPIOIN = 17'h0AB00;
        repeat (4) step();
        bus_write(32'h0C, 32'hFFFF);
        GPIOIN = 17'h0AB01;
        step();
        bus_write(32'h0C, 32'h1);
        bus_read(32'h0C, "irq_setwins", rd);
        check("irq_setwins_const", rd, 32'h1);

        // Parity error counting and saturation.
        bus_write(32'h10, 32'h2);
        GPIOIN = 17'h00003;
        repeat (5) step();
        for (int k = 0; k < 300; k++) begin
            GPIOIN = 17'h00003; step(); step();
            GPIOIN = 17'h00001; step(); step();
        end
        repeat (4) step();
        check("perr_live", 32'(PARITYERR), 32'h1);
        check_pins("perr_live");
        bus_read(32'h14, "pcnt_sat", rd);
        check("pcnt_sat_const", rd, 32'd255);
        bus_read(32'h10, "pctrl_perr", rd);
        check("pctrl_perr_const", rd, 32'h102);
        bus_write(32'h14, 32'h0);
        bus_read(32'h14, "pcnt_clr", rd);
        check("pcnt_clr_const", rd, 32'h0);
        bus_write(32'h10, 32'h102);
        bus_read(32'h10, "perr_clr", rd);
        check("perr_clr_const", rd, 32'h2);

        // Unmapped offsets.
        bus_write(32'h18, 32'hFFFFFFFF);
        bus_read(32'h18, "off18", rd);
        check("off18_const", rd, 32'h0);
        bus_read(32'h1C, "off1c", rd);
        check("off1c_const", rd, 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(0, 9);
            rnd = $urandom;
            addr = {rnd[31:5], 3'($urandom_range(0, 7)), 2'b00};
            if (r < 3) begin
                rnd = $urandom;
                GPIOIN = rnd[W:0];
                step();
            end else if (r < 6) begin
                bus_write(addr, $urandom);
            end else if (r < 9) begin
                bus_read(addr, "rand_rd", rd);
            end else begin
                // Transfer that must not be accepted (not ready, or BUSY).
                HSEL = 1; HWRITE = rnd[0]; HADDR = addr;
                if (rnd[1]) begin HTRANS = 2'b10; HREADY = 0; end
                else        begin HTRANS = 2'b01; HREADY = 1; end
                step();
                bus_idle(); HWDATA = $urandom;
                check("rand_noaccept_hrdata", HRDATA, model_hrdata());
                step();
            end
            check_pins("rand");
        end

        // Back-to-back write then read of DIR.
        HSEL = 1; HTRANS = 2'b10; HWRITE = 1; HADDR = 32'h04;
        step();
        HWRITE = 0; HWDATA = 32'h5A5A;
        step();
        bus_idle();
        check("b2b_dir", HRDATA, 32'h5A5A);
        check("b2b_dir_model", HRDATA, model_hrdata());
        step();

        // Reset during a write data phase discards the write.
        HSEL = 1; HTRANS = 2'b10; HWRITE = 1; HADDR = 32'h04;
        step();
        bus_idle(); HWDATA = 32'h1234; HRESET = 1;
        step();
        HRESET = 0;
        step();
        bus_read(32'h04, "rst_mid_dir", rd);
        check("rst_mid_dir_const", rd, 32'h0);
        check_pins("rst_mid");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
